// File: rtl/cozy_pkg.sv
// Shared constants for the cozy memory datapath: bus widths and the
// write-control encodings carried on bwe.
package cozy_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  localparam logic [1:0] BWE_READ = 2'b00;
  localparam logic [1:0] BWE_BYTE = 2'b01;
  localparam logic [1:0] BWE_NOP  = 2'b10;
  localparam logic [1:0] BWE_WORD = 2'b11;

endpackage

// File: rtl/cozy_memory_lane.sv
// One 8-bit byte lane of the cozy memory: single-port RAM with a registered,
// read-first output. There is no reset here so the array and its output
// register can map onto a block RAM primitive.
module cozy_memory_lane #(
  parameter int DEPTH = 4096,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write the addressed byte and register the pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/cozy_memory.sv
// Byte-addressable 16-bit synchronous RAM built from two byte lanes
// (ram_hi = bits 15:8, ram_lo = bits 7:0) sharing one word index.
// Optional macro COZY_MEMORY_OUTREG_EN adds an output pipeline register
// after the lane mux, giving a 2-cycle read latency instead of 1.
module cozy_memory
  import cozy_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        bwe,
  output logic [DATA_W-1:0] dout
);

  localparam int IW = $clog2(DEPTH);

  logic [IW-1:0] idx;
  logic          byte_sel;
  logic          we_hi;
  logic          we_lo;
  logic [7:0]    wdata_hi;
  logic [7:0]    wdata_lo;
  logic [7:0]    rdata_hi;
  logic [7:0]    rdata_lo;
  logic          sel_reg;
  logic          clr_reg;
  logic [DATA_W-1:0] read_word;

  assign idx      = addr[IW:1];
  assign byte_sel = addr[0];

  // Address bits above the word index are deliberately ignored so that
  // addresses alias modulo 2*DEPTH bytes.
  if (IW + 1 < ADDR_W) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:IW+1];
  end

  // Lane write-enable decode: a word write hits both lanes, a byte write
  // hits the lane picked by the address parity, anything else writes nothing.
  always_comb begin
    we_hi = 1'b0;
    we_lo = 1'b0;
    if (bwe == BWE_WORD) begin
      we_hi = 1'b1;
      we_lo = 1'b1;
    end else if (bwe == BWE_BYTE) begin
      we_hi = byte_sel;
      we_lo = ~byte_sel;
    end
  end

  // A byte write always carries its data in din[7:0], even for the hi lane.
  assign wdata_hi = (bwe == BWE_WORD) ? din[15:8] : din[7:0];
  assign wdata_lo = din[7:0];

  cozy_memory_lane #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) ram_hi (
    .clk   (clk),
    .we    (we_hi),
    .idx   (idx),
    .wdata (wdata_hi),
    .rdata (rdata_hi)
  );

  cozy_memory_lane #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) ram_lo (
    .clk   (clk),
    .we    (we_lo),
    .idx   (idx),
    .wdata (wdata_lo),
    .rdata (rdata_lo)
  );

  // Track the byte select alongside the lane read, and hold the output at
  // zero from reset until the first post-reset edge reloads the lanes.
  // Gating after the RAM keeps the reset off the block RAM registers while
  // still clearing dout the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg <= 1'b0;
      clr_reg <= 1'b1;
    end else begin
      sel_reg <= byte_sel;
      clr_reg <= 1'b0;
    end
  end

  // Read mux: full word on even addresses, zero-extended hi byte on odd.
  always_comb begin
    read_word = {rdata_hi, rdata_lo};
    if (sel_reg) begin
      read_word = {8'h00, rdata_hi};
    end
    if (clr_reg) begin
      read_word = '0;
    end
  end

`ifdef COZY_MEMORY_OUTREG_EN
  logic [DATA_W-1:0] out_reg;

  // Extra output stage after the lane mux for timing closure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg <= '0;
    end else begin
      out_reg <= read_word;
    end
  end

  assign dout = out_reg;
`else
  assign dout = read_word;
`endif

endmodule

// File: tb/tb_cozy_memory.sv
// Directed bench for cozy_memory at DEPTH=4 with hand-computed expectations.
// Honours COZY_MEMORY_OUTREG_EN by waiting one extra cycle per operation.
module tb_cozy_memory;
  import cozy_pkg::*;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [1:0]        bwe;
  logic [DATA_W-1:0] dout;

  int n_tests;
  int n_fail;

  cozy_memory #(.DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .din  (din),
    .bwe  (bwe),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %04h expected %04h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: dout=%04h", tag, got);
    end
  endtask

  // Present one operation, clock it in, and leave dout showing its read result.
  task automatic op(input logic [12:0] a, input logic [15:0] d, input logic [1:0] b);
    addr = a;
    din  = d;
    bwe  = b;
    @(posedge clk);
    #1;
`ifdef COZY_MEMORY_OUTREG_EN
    bwe = BWE_READ;
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic rd(input string tag, input logic [12:0] a, input logic [15:0] exp);
    op(a, 16'h0000, BWE_READ);
    check(tag, dout, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b1;
    addr = '0;
    din  = '0;
    bwe  = BWE_READ;

    @(posedge clk);
    #1;
    check("reset_dout", dout, 16'h0000);
    rst = 1'b0;

    // Word writes
    op(13'd0, 16'h1234, BWE_WORD);
    op(13'd2, 16'h5678, BWE_WORD);
    op(13'd4, 16'h9ABC, BWE_WORD);
    op(13'd6, 16'hCDEF, BWE_WORD);
    rd("word_rd_0", 13'd0, 16'h1234);
    rd("word_rd_6", 13'd6, 16'hCDEF);

    // Byte writes to each lane of word 0
    op(13'd0, 16'hABCD, BWE_BYTE);
    rd("lo_byte_wr", 13'd0, 16'h12CD);
    op(13'd1, 16'hBCDE, BWE_BYTE);
    rd("hi_byte_wr", 13'd0, 16'hDECD);

    // Reads: word and zero-extended odd byte
    rd("rd_odd_1", 13'd1, 16'h00DE);
    rd("rd_word_2", 13'd2, 16'h5678);
    rd("rd_odd_3", 13'd3, 16'h0056);
    rd("rd_word_4", 13'd4, 16'h9ABC);

    // Aliasing modulo 8 bytes, including high address bits
    rd("alias_8", 13'd8, 16'hDECD);
    rd("alias_9", 13'd9, 16'h00DE);
    rd("alias_1006", 13'h1006, 16'hCDEF);

    // Reserved bwe=10 behaves as a read, writes nothing
    op(13'd2, 16'hFFFF, BWE_NOP);
    check("nop_reads", dout, 16'h5678);
    rd("nop_kept", 13'd2, 16'h5678);

    // Read-during-write returns old contents
    op(13'd6, 16'h1111, BWE_WORD);
    check("rdw_word_old", dout, 16'hCDEF);
    rd("rdw_word_new", 13'd6, 16'h1111);
    op(13'd7, 16'h0022, BWE_BYTE);
    check("rdw_byte_old", dout, 16'h0011);
    rd("rdw_byte_new", 13'd6, 16'h2211);

    // dout holds until the next sampling edge
    rd("hold_pre", 13'd0, 16'hDECD);
    addr = 13'd2;
    #2;
    check("hold_no_edge", dout, 16'hDECD);

    // Asynchronous reset mid-read; contents survive, writes still land
    rd("pre_reset", 13'd4, 16'h9ABC);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", dout, 16'h0000);
    op(13'd2, 16'h4242, BWE_WORD);
    check("rst_holds", dout, 16'h0000);
    rst = 1'b0;
    rd("post_rst_4", 13'd4, 16'h9ABC);
    rd("wr_in_rst", 13'd2, 16'h4242);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
